// File: rtl/md_unit.sv
// Iterative-latency multiply/divide unit with HI/LO registers (mult/multu 5 cycles, div/divu 10 cycles).
// Optional MDU_DIVZERO_GUARD_EN: divide by zero leaves HI/LO untouched instead of HI=A, LO=all-ones.
module md_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdop,
  input  logic        hlwrite,
  input  logic        hlsel,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] out
);

  localparam logic [3:0] MUL_CYCLES = 4'd5;
  localparam logic [3:0] DIV_CYCLES = 4'd10;

  logic [31:0] r_hi, r_lo, r_a, r_b;
  logic [1:0]  r_op;
  logic [3:0]  r_cnt;
  logic        r_busy;

  logic        w_div, w_sgn, w_an, w_bn, w_bz;
  logic [31:0] w_amag, w_bmag, w_bdiv, w_q, w_r;
  logic [63:0] w_prod;
  logic        w_res_we;
  logic [31:0] w_hi_res, w_lo_res;

  assign busy = r_busy;
  assign out  = hlsel ? r_lo : r_hi;

  assign w_div = r_op[1];
  assign w_sgn = ~r_op[0];
  assign w_an  = w_sgn & r_a[31];
  assign w_bn  = w_sgn & r_b[31];
  assign w_bz  = (r_b == 32'd0);

  // Sign-extended operands in a 64-bit multiply give the exact signed product modulo 2^64.
  assign w_prod = w_sgn ? ({{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b})
                        : ({32'd0, r_a} * {32'd0, r_b});

  // Divide on magnitudes so signed overflow (MIN / -1) simply wraps.
  assign w_amag = w_an ? (~r_a + 32'd1) : r_a;
  assign w_bmag = w_bn ? (~r_b + 32'd1) : r_b;
  assign w_bdiv = w_bz ? 32'd1 : w_bmag;
  assign w_q    = w_amag / w_bdiv;
  assign w_r    = w_amag % w_bdiv;

  always_comb begin
    w_res_we = 1'b1;
    w_hi_res = w_prod[63:32];
    w_lo_res = w_prod[31:0];
    if (w_div) begin
      if (w_bz) begin
`ifdef MDU_DIVZERO_GUARD_EN
        w_res_we = 1'b0;
        w_hi_res = r_hi;
        w_lo_res = r_lo;
`else
        w_hi_res = r_a;
        w_lo_res = 32'hFFFF_FFFF;
`endif
      end else begin
        w_lo_res = (w_an ^ w_bn) ? (~w_q + 32'd1) : w_q;
        w_hi_res = w_an ? (~w_r + 32'd1) : w_r;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi   <= 32'd0;
      r_lo   <= 32'd0;
      r_a    <= 32'd0;
      r_b    <= 32'd0;
      r_op   <= 2'd0;
      r_cnt  <= 4'd0;
      r_busy <= 1'b0;
    end else if (r_busy) begin
      r_cnt <= r_cnt - 4'd1;
      if (r_cnt == 4'd1) begin
        r_busy <= 1'b0;
        if (w_res_we) begin
          r_hi <= w_hi_res;
          r_lo <= w_lo_res;
        end
      end
    end else if (start) begin
      // Any idle start, even a reserved opcode, swallows a same-cycle hlwrite.
      if (!mdop[2]) begin
        r_a    <= A;
        r_b    <= B;
        r_op   <= mdop[1:0];
        r_cnt  <= mdop[1] ? DIV_CYCLES : MUL_CYCLES;
        r_busy <= 1'b1;
      end
    end else if (hlwrite) begin
      if (hlsel) r_lo <= A;
      else       r_hi <= A;
    end
  end

endmodule
